// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MAR/MDR register pair and SRAM access sequencer.
// Loads MAR/MDR from the datapath bus while idle, runs fixed-length read or
// write cycles and returns read data into MDR. Outputs are decoded from
// registered state only, so there is no input-to-output combinational path.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              mem_ready,
  output logic              busy
);

  // Counter wide enough to hold WAIT_CYCLES-1; at least one bit.
  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    DONE       = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;

  logic              mem_ce_s;
  logic              mem_we_s;
  logic              mem_ready_s;
  logic              busy_s;

  // State register; reset forces IDLE regardless of any request.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: address, data and wait counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= CNT_ZERO;
      mar_q <= {DATA_W{1'b0}};
      mdr_q <= {DATA_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
    end
  end

  // Next-state logic: requests are only accepted from IDLE, read has priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d = READ_WAIT;
        end else if (wr_req) begin
          state_d = WRITE_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      READ_WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = DONE;
        end else begin
          state_d = READ_WAIT;
        end
      end
      WRITE_WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = DONE;
        end else begin
          state_d = WRITE_WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: bus loads while idle, countdown and read capture while busy.
  always_comb begin
    mar_d = mar_q;
    mdr_d = mdr_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (LD_MAR) begin
          mar_d = bus_in;
        end else begin
          mar_d = mar_q;
        end
        if (LD_MDR) begin
          mdr_d = bus_in;
        end else begin
          mdr_d = mdr_q;
        end
        if (rd_req || wr_req) begin
          cnt_d = CNT_LOAD;
        end else begin
          cnt_d = cnt_q;
        end
      end
      READ_WAIT: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          mdr_d = mem_rdata;
        end
      end
      WRITE_WAIT: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the registered state only.
  always_comb begin
    mem_ce_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_ready_s = 1'b0;
    busy_s      = 1'b1;
    case (state_q)
      IDLE: begin
        busy_s = 1'b0;
      end
      READ_WAIT: begin
        mem_ce_s = 1'b1;
      end
      WRITE_WAIT: begin
        mem_ce_s = 1'b1;
        mem_we_s = 1'b1;
      end
      DONE: begin
        mem_ready_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign MAR       = mar_q;
  assign MDR       = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_ce    = mem_ce_s;
  assign mem_we    = mem_we_s;
  assign mem_ready = mem_ready_s;
  assign busy      = busy_s;

endmodule
